// File: rtl/nios_led_pio_pkg.sv
// Register map shared by the nios_led_pio slave and anything that decodes its addresses.
package nios_led_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

endpackage

// File: rtl/nios_led_blink_timer.sv
// Half-period counter and phase flop for the LED blink engine (used only with NIOS_LED_PIO_BLINK_EN).
module nios_led_blink_timer #(
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                restart,
  input  logic [PERIOD_W-1:0] period,
  output logic                phase
);

  logic [PERIOD_W-1:0] cnt;

  // restart wins over a terminal count landing on the same edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (restart || !enable) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == period) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/nios_led_pio.sv
// Avalon-MM output PIO with set/clear aliases; optional blink engine under NIOS_LED_PIO_BLINK_EN.
module nios_led_pio
  import nios_led_pio_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter logic [31:0] RESET_VALUE  = 32'd1,
  parameter int unsigned PERIOD_W     = 24,
  parameter logic [31:0] PERIOD_RESET = 32'd5000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data;
  logic             unused_bits;

  assign wr_en       = chipselect & ~write_n;
  assign wd          = writedata[WIDTH-1:0];
  assign unused_bits = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= RESET_VALUE[WIDTH-1:0];
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:     data <= wd;
        ADDR_OUTSET:   data <= data | wd;
        ADDR_OUTCLEAR: data <= data & ~wd;
        default:       ;
      endcase
    end
  end

`ifdef NIOS_LED_PIO_BLINK_EN
  logic [WIDTH-1:0]    mask;
  logic [PERIOD_W-1:0] period;
  logic                restart;
  logic                phase;

  assign restart = wr_en && (address == ADDR_PERIOD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask   <= '0;
      period <= PERIOD_RESET[PERIOD_W-1:0];
    end else if (wr_en) begin
      if (address == ADDR_MASK)   mask   <= wd;
      if (address == ADDR_PERIOD) period <= writedata[PERIOD_W-1:0];
    end
  end

  nios_led_blink_timer #(.PERIOD_W(PERIOD_W)) u_blink_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (|mask),
    .restart (restart),
    .period  (period),
    .phase   (phase)
  );

  // masked bits are forced low during the off phase
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_port <= RESET_VALUE[WIDTH-1:0];
    else          out_port <= data & ~(mask & {WIDTH{~phase}});
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[WIDTH-1:0]    = data;
      ADDR_MASK:   readdata[WIDTH-1:0]    = mask;
      ADDR_PERIOD: readdata[PERIOD_W-1:0] = period;
      ADDR_STATUS: readdata[0]            = phase;
      default:     ;
    endcase
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_port <= RESET_VALUE[WIDTH-1:0];
    else          out_port <= data;
  end

  always_comb begin
    readdata = '0;
    if (address == ADDR_DATA) readdata[WIDTH-1:0] = data;
  end
`endif

endmodule

// File: tb/tb_nios_led_pio.sv
// Randomised self-checking bench for nios_led_pio against a tick-counting model; honours NIOS_LED_PIO_BLINK_EN.
module tb_nios_led_pio;

`ifdef NIOS_LED_PIO_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif
  localparam logic [31:0] PERIOD_RST = 32'd5000000;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_data;
  logic [7:0] m_mask;
  logic [7:0] m_out;
  longint     m_period;
  longint     ticks;

  nios_led_pio #(
    .WIDTH(8), .RESET_VALUE(32'd1), .PERIOD_W(24), .PERIOD_RESET(PERIOD_RST)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    m_data   = 8'h01;
    m_mask   = 8'h00;
    m_period = longint'(PERIOD_RST);
    ticks    = 0;
    m_out    = 8'h01;
  endtask

  // phase derived from how many enabled cycles have elapsed since the last restart
  function automatic logic model_phase();
    if (!BLINK) return 1'b1;
    return ((ticks / (m_period + 1)) % 2) == 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return {24'b0, m_data};
      3'd1: return BLINK ? {24'b0, m_mask} : 32'd0;
      3'd2: return BLINK ? 32'(m_period) : 32'd0;
      3'd3: return BLINK ? {31'b0, model_phase()} : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic applyStimulus(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
    logic [7:0] off_mask;
    logic       wr;
    chipselect = cs; write_n = wn; address = a; writedata = d;
    #1;
    if (cs) checkOutput($sformatf("read_addr%0d", a), readdata, model_read(a));
    @(posedge clk);
    off_mask = model_phase() ? 8'h00 : m_mask;
    m_out    = m_data & ~off_mask;
    wr       = cs && !wn;
    if ((wr && BLINK && a == 3'd2) || m_mask == 8'h00) ticks = 0;
    else ticks++;
    if (wr) begin
      case (a)
        3'd0: m_data = d[7:0];
        3'd1: if (BLINK) m_mask = d[7:0];
        3'd2: if (BLINK) m_period = longint'(d[23:0]);
        3'd4: m_data = m_data | d[7:0];
        3'd5: m_data = m_data & ~d[7:0];
        default: ;
      endcase
    end
    @(negedge clk);
    checkOutput("out_port", {24'b0, out_port}, {24'b0, m_out});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 3'(i % 4), 32'hDEAD_BEEF);
  endtask

  initial begin
    logic [2:0]  ra;
    logic [31:0] rd;
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = '0;
    modelReset();
    @(negedge clk);
    checkOutput("reset_out", {24'b0, out_port}, 32'h01);
    @(negedge clk);
    reset_n = 1'b1;

    // reset-state reads and quiet outputs
    idle(8);

    // DATA, OUTSET, OUTCLEAR sequence
    applyStimulus(1'b1, 1'b0, 3'd0, 32'hFFFF_FFA5);
    applyStimulus(1'b1, 1'b0, 3'd4, 32'h0000_000A);
    applyStimulus(1'b1, 1'b0, 3'd5, 32'h0000_0081);
    applyStimulus(1'b1, 1'b1, 3'd0, 32'h0);
    checkOutput("data_after_clear", readdata, 32'h2E);

    // blink with half-period 4
    applyStimulus(1'b1, 1'b0, 3'd2, 32'hAB00_0003);
    applyStimulus(1'b1, 1'b0, 3'd0, 32'h0000_00FF);
    applyStimulus(1'b1, 1'b0, 3'd1, 32'h0000_000F);
    idle(14);

    // restart from phase 0 with a shorter period
    for (int i = 0; i < 10 && model_phase() == 1'b1 && BLINK; i++) idle(1);
    applyStimulus(1'b1, 1'b0, 3'd2, 32'h0000_0001);
    idle(8);

    // reserved addresses swallow writes
    applyStimulus(1'b1, 1'b0, 3'd6, 32'h1234_5678);
    applyStimulus(1'b1, 1'b0, 3'd7, 32'h8765_4321);
    for (int a = 4; a < 8; a++) applyStimulus(1'b1, 1'b1, 3'(a), 32'h0);
    idle(4);

    // asynchronous reset mid-blink
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_out", {24'b0, out_port}, 32'h01);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle(12);

    // randomised traffic
    for (int i = 0; i < 400; i++) begin
      ra = 3'($urandom_range(0, 7));
      rd = $urandom;
      if (ra == 3'd2) rd = (rd & 32'hFF00_0000) | 32'($urandom_range(0, 6));
      if (ra == 3'd1 && $urandom_range(0, 3) == 0) rd = 32'h0;
      applyStimulus($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), ra, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
